// File: rtl/acc_unit.sv
// acc_unit: calculator accumulator with an opcode-driven ALU step, a memory
// register (M-store / M+), a sticky signed-overflow flag with optional
// saturation, and a DEPTH-entry undo history (LIFO, the oldest entry is
// overwritten when the history is full).
module acc_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           EN,
    input  logic [2:0]                     OP,
    input  logic [WIDTH-1:0]               IN,
    output logic [WIDTH-1:0]               OUT,
    output logic [WIDTH-1:0]               MEM_OUT,
    output logic                           OVF,
    output logic                           ZERO,
    output logic [$clog2(DEPTH+1)-1:0]     HIST_CNT,
    output logic                           ERR
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_CLR    = 3'b100;
    localparam logic [2:0] OP_MSTORE = 3'b101;
    localparam logic [2:0] OP_MADD   = 3'b110;
    localparam logic [2:0] OP_UNDO   = 3'b111;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0]    LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mem;
    logic             r_ovf;
    logic             r_err;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_wp;      // next write slot; the top entry sits just below it
    logic [WIDTH-1:0] r_hist [DEPTH];

    logic [WIDTH:0]   w_ext;     // sign-extended WIDTH+1 sum or difference
    logic             w_arith_ovf;
    logic [WIDTH-1:0] w_arith;
    logic [PW-1:0]    w_top;
    logic [PW-1:0]    w_wp_inc;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mem_next;
    logic             w_ovf_next;
    logic             w_push;
    logic             w_pop;
    logic             w_err_next;

    assign w_top    = (r_wp == '0) ? LAST : r_wp - 1'b1;
    assign w_wp_inc = (r_wp == LAST) ? '0 : r_wp + 1'b1;

    // ALU result: overflow is the mismatch of the two top bits of the extended result
    always_comb begin
        w_ext = '0;
        if (OP == OP_SUB)
            w_ext = {r_acc[WIDTH-1], r_acc} - {IN[WIDTH-1], IN};
        else
            w_ext = {r_acc[WIDTH-1], r_acc} + {IN[WIDTH-1], IN};
        w_arith_ovf = w_ext[WIDTH] ^ w_ext[WIDTH-1];
        w_arith     = w_ext[WIDTH-1:0];
        if (SAT != 0 && w_arith_ovf)
            w_arith = w_ext[WIDTH] ? SMIN : SMAX;
    end

    // Opcode decode into next-state values and history push/pop requests
    always_comb begin
        w_acc_next = r_acc;
        w_mem_next = r_mem;
        w_ovf_next = r_ovf;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_err_next = 1'b0;
        if (EN) begin
            case (OP)
                OP_NOP: ;
                OP_LOAD: begin
                    w_acc_next = IN;
                    w_push     = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    w_acc_next = w_arith;
                    w_ovf_next = r_ovf | w_arith_ovf;
                    w_push     = 1'b1;
                end
                OP_CLR: begin
                    w_acc_next = '0;
                    w_ovf_next = 1'b0;
                    w_push     = 1'b1;
                end
                OP_MSTORE: w_mem_next = r_acc;
                OP_MADD:   w_mem_next = r_mem + r_acc;
                OP_UNDO: begin
                    if (r_cnt != '0) begin
                        w_acc_next = r_hist[w_top];
                        w_pop      = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator, memory, flags and history bookkeeping
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc <= '0;
            r_mem <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
            r_wp  <= '0;
        end else begin
            r_acc <= w_acc_next;
            r_mem <= w_mem_next;
            r_ovf <= w_ovf_next;
            r_err <= w_err_next;
            if (w_push) begin
                r_wp <= w_wp_inc;
                if (r_cnt != FULL)
                    r_cnt <= r_cnt + 1'b1;
            end else if (w_pop) begin
                r_wp  <= w_top;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // History storage: each slot captures the pre-op accumulator when it is the write slot
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hist
            always_ff @(posedge CLK) begin
                if (!RESET && w_push && (r_wp == PW'(gi)))
                    r_hist[gi] <= r_acc;
            end
        end
    endgenerate

    assign OUT      = r_acc;
    assign MEM_OUT  = r_mem;
    assign OVF      = r_ovf;
    assign ERR      = r_err;
    assign HIST_CNT = r_cnt;
    assign ZERO     = (r_acc == '0);

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit: a wrapping (SAT=0) and a saturating (SAT=1)
// instance share the same stimulus; expected values are hand-computed.
module tb_acc_unit;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        EN = 1'b0;
    logic [2:0]  OP = 3'b000;
    logic [15:0] IN = 16'h0000;

    logic [15:0] out_a, mem_a, out_b, mem_b;
    logic        ovf_a, zero_a, err_a, ovf_b, zero_b, err_b;
    logic [2:0]  hc_a, hc_b;

    int tests = 0;
    int failed = 0;

    acc_unit #(.WIDTH(16), .DEPTH(4), .SAT(0)) u_wrap (
        .CLK(CLK), .RESET(RESET), .EN(EN), .OP(OP), .IN(IN),
        .OUT(out_a), .MEM_OUT(mem_a), .OVF(ovf_a), .ZERO(zero_a),
        .HIST_CNT(hc_a), .ERR(err_a)
    );

    acc_unit #(.WIDTH(16), .DEPTH(4), .SAT(1)) u_sat (
        .CLK(CLK), .RESET(RESET), .EN(EN), .OP(OP), .IN(IN),
        .OUT(out_b), .MEM_OUT(mem_b), .OVF(ovf_b), .ZERO(zero_b),
        .HIST_CNT(hc_b), .ERR(err_b)
    );

    always #5 CLK = ~CLK;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           CLR = 3'd4, MST = 3'd5, MADD = 3'd6, UNDO = 3'd7;

    // Drive one cycle of inputs at a falling edge, let the rising edge sample
    // them, and return at the next falling edge where outputs are stable.
    task automatic step(input logic rst, input logic en, input logic [2:0] op,
                        input logic [15:0] val);
        RESET = rst;
        EN    = en;
        OP    = op;
        IN    = val;
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full check of the wrapping instance
    task automatic chk_a(input string tag, input logic [15:0] o, input logic [15:0] m,
                         input logic v, input logic [2:0] h, input logic e);
        chk({tag, ".out"},  {16'h0, out_a}, {16'h0, o});
        chk({tag, ".mem"},  {16'h0, mem_a}, {16'h0, m});
        chk({tag, ".ovf"},  {31'h0, ovf_a}, {31'h0, v});
        chk({tag, ".hcnt"}, {29'h0, hc_a},  {29'h0, h});
        chk({tag, ".err"},  {31'h0, err_a}, {31'h0, e});
        chk({tag, ".zero"}, {31'h0, zero_a}, {31'h0, (o == 16'h0)});
        $display("[TB] %s: out=%h mem=%h ovf=%b hcnt=%0d err=%b", tag, out_a, mem_a, ovf_a, hc_a, err_a);
    endtask

    // Accumulator and overflow check of the saturating instance
    task automatic chk_b(input string tag, input logic [15:0] o, input logic v);
        chk({tag, ".sat_out"}, {16'h0, out_b}, {16'h0, o});
        chk({tag, ".sat_ovf"}, {31'h0, ovf_b}, {31'h0, v});
        $display("[TB] %s (sat): out=%h ovf=%b", tag, out_b, ovf_b);
    endtask

    initial begin
        @(negedge CLK);

        // 1. Reset overrides an ADD
        step(1, 1, ADD, 16'h1234);
        chk_a("reset", 16'h0000, 16'h0000, 0, 3'd0, 0);
        chk_b("reset", 16'h0000, 0);

        // 2. Basic ops
        step(0, 1, LOAD, 16'h6AB3);
        chk_a("load", 16'h6AB3, 16'h0, 0, 3'd1, 0);
        step(0, 1, ADD, 16'h0800);
        chk_a("add", 16'h72B3, 16'h0, 0, 3'd2, 0);
        step(0, 0, SUB, 16'h1111);
        chk_a("en_low", 16'h72B3, 16'h0, 0, 3'd2, 0);
        step(0, 1, SUB, 16'h72B3);
        chk_a("sub_zero", 16'h0000, 16'h0, 0, 3'd3, 0);

        // 3. Positive overflow, sticky flag, clear
        step(0, 1, LOAD, 16'h7FFF);
        chk_a("load_max", 16'h7FFF, 16'h0, 0, 3'd4, 0);
        step(0, 1, ADD, 16'h0001);
        chk_a("ovf_pos", 16'h8000, 16'h0, 1, 3'd4, 0);
        chk_b("ovf_pos", 16'h7FFF, 1);
        step(0, 1, SUB, 16'h0001);
        chk_a("ovf_sticky", 16'h7FFF, 16'h0, 1, 3'd4, 0);
        chk_b("ovf_sticky", 16'h7FFE, 1);
        step(0, 1, CLR, 16'h0000);
        chk_a("clr", 16'h0000, 16'h0, 0, 3'd4, 0);
        chk_b("clr", 16'h0000, 0);

        // Negative overflow
        step(0, 1, LOAD, 16'h8000);
        step(0, 1, SUB, 16'h0001);
        chk_a("ovf_neg", 16'h7FFF, 16'h0, 1, 3'd4, 0);
        chk_b("ovf_neg", 16'h8000, 1);

        // 4. Undo and depth
        step(1, 0, NOP, 16'h0);
        for (int i = 1; i <= 5; i++) step(0, 1, LOAD, 16'(i));
        chk_a("hist_full", 16'd5, 16'h0, 0, 3'd4, 0);
        step(0, 1, UNDO, 16'h0);
        chk_a("undo1", 16'd4, 16'h0, 0, 3'd3, 0);
        step(0, 1, UNDO, 16'h0);
        chk_a("undo2", 16'd3, 16'h0, 0, 3'd2, 0);
        step(0, 1, UNDO, 16'h0);
        chk_a("undo3", 16'd2, 16'h0, 0, 3'd1, 0);
        step(0, 1, UNDO, 16'h0);
        chk_a("undo4", 16'd1, 16'h0, 0, 3'd0, 0);
        step(0, 1, UNDO, 16'h0);
        chk_a("undo_empty", 16'd1, 16'h0, 0, 3'd0, 1);
        step(0, 1, NOP, 16'h0);
        chk_a("err_clears", 16'd1, 16'h0, 0, 3'd0, 0);

        // 5. Memory
        step(1, 0, NOP, 16'h0);
        step(0, 1, LOAD, 16'h0F00);
        step(0, 1, MST, 16'h0);
        chk_a("mstore", 16'h0F00, 16'h0F00, 0, 3'd1, 0);
        step(0, 1, MADD, 16'h0);
        chk_a("madd", 16'h0F00, 16'h1E00, 0, 3'd1, 0);
        step(0, 1, UNDO, 16'h0);
        chk_a("mem_undo", 16'h0000, 16'h1E00, 0, 3'd0, 0);

        // 6. Reset mid-operation
        step(1, 0, NOP, 16'h0);
        step(0, 1, LOAD, 16'h7FFF);
        step(0, 1, ADD, 16'h0001);
        step(0, 1, LOAD, 16'h00AA);
        step(0, 1, MST, 16'h0);
        chk_a("pre_reset", 16'h00AA, 16'h00AA, 1, 3'd3, 0);
        step(1, 1, UNDO, 16'h0);
        chk_a("mid_reset", 16'h0000, 16'h0000, 0, 3'd0, 0);
        step(0, 1, UNDO, 16'h0);
        chk_a("undo_after_reset", 16'h0000, 16'h0000, 0, 3'd0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/acc_unit.md
Name: acc_unit

Overview:
Parametrised accumulator for the pocket-calculator datapath; next generation of the plain 16-bit enable/load accumulator register. Adds an opcode-driven ALU step (load/add/subtract/clear), a memory register (calculator M-store/M+), a sticky signed-overflow flag with optional saturation, and a DEPTH-entry undo history. Sits between the keypad/ALU operand path and the display driver.

Parameters:
WIDTH, 16, data width in bits (two's complement); legal range >= 2.
DEPTH, 4, number of undo history entries; legal range >= 1.
SAT, 0, 0 = ADD/SUB wrap modulo 2^WIDTH; 1 = saturate to the signed maximum or minimum.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous active-high reset.
EN  input  1  operation enable; when low, all state is held.
OP  input  3  opcode, sampled when EN=1.
IN  input  WIDTH  operand.
OUT  output  WIDTH  accumulator value (registered).
MEM_OUT  output  WIDTH  memory register value (registered).
OVF  output  1  sticky signed-overflow flag (registered).
ZERO  output  1  combinational; 1 when OUT == 0.
HIST_CNT  output  $clog2(DEPTH+1)  number of valid history entries (registered).
ERR  output  1  one-cycle pulse on an illegal UNDO (registered).

Behaviour:
- Reset, decided: one clock; RESET is synchronous and active-high.
  - RESET=1 at an edge sets OUT=0, MEM_OUT=0, OVF=0, HIST_CNT=0 and ERR=0, and clears the history.
  - RESET overrides EN and OP.
  - Asserting RESET mid-sequence discards all history.
- Latency: one cycle. A result is visible on OUT/MEM_OUT/OVF/HIST_CNT after the edge on which the op is sampled. Operations issue back-to-back every cycle.
- EN=0: all registers hold and ERR=0. OP and IN are ignored.
- Opcodes (apply when EN=1):
  - 000 NOP: hold all state.
  - 001 LOAD: acc <= IN.
  - 010 ADD: acc <= acc + IN.
  - 011 SUB: acc <= acc - IN.
  - 100 CLR: acc <= 0 and OVF <= 0.
  - 101 MSTORE: mem <= acc.
  - 110 MADD: mem <= mem + acc, wrapping, with no effect on OVF.
  - 111 UNDO: restore the previous accumulator value (see History).
- Arithmetic:
  - Signed overflow is detected on the full WIDTH+1 result.
  - On overflow, OVF is set to 1 and stays set until CLR or RESET.
  - SAT=0: the result wraps.
  - SAT=1: the result clamps to 2^(WIDTH-1)-1 on positive overflow and to -2^(WIDTH-1) on negative overflow.
- History (LIFO with overwrite-oldest):
  - LOAD, ADD, SUB and CLR push the pre-op acc value, even if the value does not change.
  - NOP, MSTORE and MADD do not push.
  - Push while HIST_CNT < DEPTH: HIST_CNT increments.
  - Push while HIST_CNT == DEPTH: the oldest entry is discarded and HIST_CNT stays at DEPTH.
  - UNDO with HIST_CNT > 0: acc <= top entry and HIST_CNT decrements. OVF and mem are unchanged.
  - UNDO with HIST_CNT == 0: acc is unchanged and ERR pulses high for exactly one cycle.
  - ERR is 0 on every other cycle.
- MEM_OUT changes only on MSTORE, MADD or RESET.

Test Plan:
1. Reset: drive RESET=1 with EN=1, OP=010, IN=0x1234 for one edge -> OUT=0x0000, MEM_OUT=0x0000, OVF=0, HIST_CNT=0, ZERO=1.
2. Basic ops (WIDTH=16):
   - LOAD 0x6AB3 then ADD 0x0800 -> OUT=0x72B3, HIST_CNT=2.
   - Then EN=0 with OP=011 -> OUT stays 0x72B3.
   - Then SUB 0x72B3 -> OUT=0x0000, ZERO=1.
3. Overflow:
   - LOAD 0x7FFF, ADD 0x0001 -> SAT=0 gives OUT=0x8000, OVF=1; SAT=1 gives OUT=0x7FFF, OVF=1.
   - Following SUB 0x0001 -> OVF remains 1.
   - CLR -> OUT=0, OVF=0.
4. Undo and depth (DEPTH=4):
   - After reset, LOAD 1,2,3,4,5 -> HIST_CNT=4.
   - UNDO x4 -> OUT=4,3,2,1 in sequence, HIST_CNT falling to 0.
   - Fifth UNDO -> OUT=1, ERR=1 for one cycle, then ERR=0.
5. Memory:
   - LOAD 0x0F00, MSTORE, MADD -> MEM_OUT=0x1E00, OUT=0x0F00, HIST_CNT=1.
   - UNDO -> OUT=0x0000, MEM_OUT=0x1E00.
6. Reset mid-operation:
   - Build HIST_CNT=3, MEM_OUT=0x00AA, OVF=1.
   - Assert RESET together with OP=111 -> all outputs zero next cycle.
   - Following UNDO -> ERR=1.
